// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the pipelined ARM-style control path:
//   - ARM condition-field encodings (COND_EQ .. COND_AL)
//   - forwarding-mux select codes (FWD_RF, FWD_W, FWD_M)
//   - bit positions of N, Z, C, V inside the 4-bit flag vectors
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from Memory-stage ALU result

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/pipe_cond_eval.sv
// ---------------------------------------------------------------------------
// pipe_cond_eval
// Purely combinational ARM condition-code evaluator.
// Ports:
//   CondE   in  4  condition field of the instruction in Execute
//   FlagsR  in  4  current {N,Z,C,V} flag register
//   CondExE out 1  1 when the instruction is allowed to take effect
// ---------------------------------------------------------------------------
module pipe_cond_eval
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsR,
  output logic       CondExE
);

  logic n, z, c, v;

  assign n = FlagsR[FLAG_N];
  assign z = FlagsR[FLAG_Z];
  assign c = FlagsR[FLAG_C];
  assign v = FlagsR[FLAG_V];

  // Decode the condition field against the flags
  always_comb begin
    case (CondE)
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~(c & ~z);
      COND_GE: CondExE = ~(n ^ v);
      COND_LT: CondExE = n ^ v;
      COND_GT: CondExE = ~z & ~(n ^ v);
      COND_LE: CondExE = z | (n ^ v);
      default: CondExE = 1'b1;  // AL, and 1111 behaves as AL
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// ---------------------------------------------------------------------------
// pipe_controller
// Control path of a 5-stage ARM-style pipeline: carries decoded controls from
// Decode through Execute/Memory/Writeback, gates them with the condition
// result, holds the flag register, and produces forwarding and hazard
// (stall/flush) signals.
//
// Build option: PIPE_CONTROLLER_FORWARD_EN
//   defined   -> E-stage operand forwarding from M/W, stall only on load-use
//   undefined -> no forwarding (selects tied to register file); stall on any
//                dependency with an instruction still in E or M
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   *D inputs               decoded controls, condition, register addresses
//   ALUFlags                {N,Z,C,V} from the ALU in Execute
//   ALUSrcE, ALUControlE    Execute-stage ALU controls
//   ForwardAE, ForwardBE    operand forwarding selects
//   BranchTakenE            conditional branch resolved taken in Execute
//   MemWriteM               condition-gated memory write
//   RegWriteW, MemtoRegW, PCSrcW  Writeback-stage controls
//   StallF, StallD, FlushD, FlushE  hazard controls
// ---------------------------------------------------------------------------
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 2,
  parameter int RA_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteD,
  input  logic                MemWriteD,
  input  logic                MemtoRegD,
  input  logic                BranchD,
  input  logic                PCSD,
  input  logic                ALUSrcD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [1:0]          FlagWriteD,
  input  logic [3:0]          CondD,
  input  logic [RA_W-1:0]     RA1D,
  input  logic [RA_W-1:0]     RA2D,
  input  logic [RA_W-1:0]     WA3D,
  input  logic [3:0]          ALUFlags,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                BranchTakenE,
  output logic                MemWriteM,
  output logic                RegWriteW,
  output logic                MemtoRegW,
  output logic                PCSrcW,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE
);

  // Execute-stage registers
  logic                regwrite_e_q, memwrite_e_q, memtoreg_e_q, branch_e_q, pcs_e_q, alusrc_e_q;
  logic                regwrite_e_d, memwrite_e_d, memtoreg_e_d, branch_e_d, pcs_e_d, alusrc_e_d;
  logic [ALUCTL_W-1:0] aluctl_e_q, aluctl_e_d;
  logic [1:0]          flagwrite_e_q, flagwrite_e_d;
  logic [3:0]          cond_e_q, cond_e_d;
  logic [RA_W-1:0]     ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
  // Memory-stage registers
  logic                regwrite_m_q, memwrite_m_q, memtoreg_m_q, pcsrc_m_q;
  logic                regwrite_m_d, memwrite_m_d, memtoreg_m_d, pcsrc_m_d;
  logic [RA_W-1:0]     wa3_m_q, wa3_m_d;
  // Writeback-stage registers
  logic                regwrite_w_q, memtoreg_w_q, pcsrc_w_q;
  logic [RA_W-1:0]     wa3_w_q;
  // Flag register
  logic [3:0]          flags_q, flags_d;

  logic cond_ex_e;
  logic ldr_stall;
  logic pc_wr_pending;

  pipe_cond_eval u_cond_eval (
    .CondE   (cond_e_q),
    .FlagsR  (flags_q),
    .CondExE (cond_ex_e)
  );

  // D->E next state: a flush inserts an all-zero bubble
  always_comb begin
    if (FlushE) begin
      regwrite_e_d  = 1'b0;
      memwrite_e_d  = 1'b0;
      memtoreg_e_d  = 1'b0;
      branch_e_d    = 1'b0;
      pcs_e_d       = 1'b0;
      alusrc_e_d    = 1'b0;
      aluctl_e_d    = {ALUCTL_W{1'b0}};
      flagwrite_e_d = 2'b00;
      cond_e_d      = 4'b0000;
      ra1_e_d       = {RA_W{1'b0}};
      ra2_e_d       = {RA_W{1'b0}};
      wa3_e_d       = {RA_W{1'b0}};
    end else begin
      regwrite_e_d  = RegWriteD;
      memwrite_e_d  = MemWriteD;
      memtoreg_e_d  = MemtoRegD;
      branch_e_d    = BranchD;
      pcs_e_d       = PCSD;
      alusrc_e_d    = ALUSrcD;
      aluctl_e_d    = ALUControlD;
      flagwrite_e_d = FlagWriteD;
      cond_e_d      = CondD;
      ra1_e_d       = RA1D;
      ra2_e_d       = RA2D;
      wa3_e_d       = WA3D;
    end
  end

  // E->M next state (side effects gated by the condition) and flag update
  always_comb begin
    regwrite_m_d = regwrite_e_q & cond_ex_e;
    memwrite_m_d = memwrite_e_q & cond_ex_e;
    pcsrc_m_d    = pcs_e_q & cond_ex_e;
    memtoreg_m_d = memtoreg_e_q;
    wa3_m_d      = wa3_e_q;
    flags_d      = flags_q;
    if (flagwrite_e_q[1] & cond_ex_e) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end else begin
      flags_d[FLAG_N] = flags_q[FLAG_N];
      flags_d[FLAG_Z] = flags_q[FLAG_Z];
    end
    if (flagwrite_e_q[0] & cond_ex_e) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end else begin
      flags_d[FLAG_C] = flags_q[FLAG_C];
      flags_d[FLAG_V] = flags_q[FLAG_V];
    end
  end

  // Pipeline and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_e_q  <= 1'b0;
      memwrite_e_q  <= 1'b0;
      memtoreg_e_q  <= 1'b0;
      branch_e_q    <= 1'b0;
      pcs_e_q       <= 1'b0;
      alusrc_e_q    <= 1'b0;
      aluctl_e_q    <= {ALUCTL_W{1'b0}};
      flagwrite_e_q <= 2'b00;
      cond_e_q      <= 4'b0000;
      ra1_e_q       <= {RA_W{1'b0}};
      ra2_e_q       <= {RA_W{1'b0}};
      wa3_e_q       <= {RA_W{1'b0}};
      regwrite_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      memtoreg_m_q  <= 1'b0;
      pcsrc_m_q     <= 1'b0;
      wa3_m_q       <= {RA_W{1'b0}};
      regwrite_w_q  <= 1'b0;
      memtoreg_w_q  <= 1'b0;
      pcsrc_w_q     <= 1'b0;
      wa3_w_q       <= {RA_W{1'b0}};
      flags_q       <= 4'b0000;
    end else begin
      regwrite_e_q  <= regwrite_e_d;
      memwrite_e_q  <= memwrite_e_d;
      memtoreg_e_q  <= memtoreg_e_d;
      branch_e_q    <= branch_e_d;
      pcs_e_q       <= pcs_e_d;
      alusrc_e_q    <= alusrc_e_d;
      aluctl_e_q    <= aluctl_e_d;
      flagwrite_e_q <= flagwrite_e_d;
      cond_e_q      <= cond_e_d;
      ra1_e_q       <= ra1_e_d;
      ra2_e_q       <= ra2_e_d;
      wa3_e_q       <= wa3_e_d;
      regwrite_m_q  <= regwrite_m_d;
      memwrite_m_q  <= memwrite_m_d;
      memtoreg_m_q  <= memtoreg_m_d;
      pcsrc_m_q     <= pcsrc_m_d;
      wa3_m_q       <= wa3_m_d;
      regwrite_w_q  <= regwrite_m_q;
      memtoreg_w_q  <= memtoreg_m_q;
      pcsrc_w_q     <= pcsrc_m_q;
      wa3_w_q       <= wa3_m_q;
      flags_q       <= flags_d;
    end
  end

`ifdef PIPE_CONTROLLER_FORWARD_EN
  // M result wins over W because it is the younger write to the register
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra,
                                         input logic [RA_W-1:0] wa_m, input logic we_m,
                                         input logic [RA_W-1:0] wa_w, input logic we_w);
    logic [1:0] sel;
    if (we_m && (ra == wa_m)) begin
      sel = FWD_M;
    end else if (we_w && (ra == wa_w)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(ra1_e_q, wa3_m_q, regwrite_m_q, wa3_w_q, regwrite_w_q);
  assign ForwardBE = fwd_sel(ra2_e_q, wa3_m_q, regwrite_m_q, wa3_w_q, regwrite_w_q);
  // Only a load in E cannot be forwarded in time
  assign ldr_stall = memtoreg_e_q & regwrite_e_q & ((RA1D == wa3_e_q) | (RA2D == wa3_e_q));
`else
  // E-stage source addresses and W destination only feed the forwarding muxes
  logic unused_fwd;
  assign unused_fwd = ^{ra1_e_q, ra2_e_q, wa3_w_q};

  assign ForwardAE = FWD_RF;
  assign ForwardBE = FWD_RF;
  // Without forwarding, wait until the producer has reached W; W needs no
  // stall since the register file writes on the falling edge
  assign ldr_stall = (regwrite_e_q & ((RA1D == wa3_e_q) | (RA2D == wa3_e_q))) |
                     (regwrite_m_q & ((RA1D == wa3_m_q) | (RA2D == wa3_m_q)));
`endif

  assign pc_wr_pending = PCSD | pcs_e_q | pcsrc_m_q;
  assign BranchTakenE  = branch_e_q & cond_ex_e;

  assign StallD = ldr_stall;
  assign StallF = ldr_stall | pc_wr_pending;
  assign FlushD = pc_wr_pending | pcsrc_w_q | BranchTakenE;
  assign FlushE = ldr_stall | BranchTakenE;

  assign ALUSrcE     = alusrc_e_q;
  assign ALUControlE = aluctl_e_q;
  assign MemWriteM   = memwrite_m_q;
  assign RegWriteW   = regwrite_w_q;
  assign MemtoRegW   = memtoreg_w_q;
  assign PCSrcW      = pcsrc_w_q;

endmodule

// File: tb/tb_pipe_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_controller
// Self-checking bench for pipe_controller. Writeback controls of an
// instruction stream are predicted into a scoreboard queue when issued and
// compared when they emerge; hazard/forwarding/flag behaviour is checked with
// directed sequences. Expectations follow PIPE_CONTROLLER_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_pipe_controller;
  import pipe_ctrl_pkg::*;

  localparam int ALUCTL_W = 2;
  localparam int RA_W     = 4;

  logic clk = 1'b0;
  logic reset;
  logic RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSD, ALUSrcD;
  logic [ALUCTL_W-1:0] ALUControlD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD;
  logic [RA_W-1:0] RA1D, RA2D, WA3D;
  logic [3:0] ALUFlags;
  logic ALUSrcE;
  logic [ALUCTL_W-1:0] ALUControlE;
  logic [1:0] ForwardAE, ForwardBE;
  logic BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
  logic StallF, StallD, FlushD, FlushE;

  pipe_controller #(.ALUCTL_W(ALUCTL_W), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .BranchD(BranchD), .PCSD(PCSD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWriteD(FlagWriteD), .CondD(CondD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .ALUFlags(ALUFlags),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic rw, mw, mtr, br, pcs, asrc;
    logic [1:0] actl, fw;
    logic [3:0] cond, ra1, ra2, wa3;
  } d_t;

  typedef struct {
    int   due;
    logic rw, mtr, pcs;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic d_t nop();
    d_t d;
    d.rw = 1'b0; d.mw = 1'b0; d.mtr = 1'b0; d.br = 1'b0; d.pcs = 1'b0; d.asrc = 1'b0;
    d.actl = 2'b00; d.fw = 2'b00; d.cond = COND_AL;
    d.ra1 = 4'd0; d.ra2 = 4'd0; d.wa3 = 4'd0;
    return d;
  endfunction

  task automatic drive(input d_t d);
    RegWriteD = d.rw; MemWriteD = d.mw; MemtoRegD = d.mtr; BranchD = d.br;
    PCSD = d.pcs; ALUSrcD = d.asrc; ALUControlD = d.actl; FlagWriteD = d.fw;
    CondD = d.cond; RA1D = d.ra1; RA2D = d.ra2; WA3D = d.wa3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive(nop());
    end
  endtask

  task automatic push(input logic rw, input logic mtr, input logic pcs);
    exp_t e;
    e.due = cyc + 3;
    e.rw = rw; e.mtr = mtr; e.pcs = pcs;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alusrc"}, ALUSrcE, 0);
    chk({tag, "_aluctl"}, ALUControlE, 0);
    chk({tag, "_fwda"}, ForwardAE, 0);
    chk({tag, "_fwdb"}, ForwardBE, 0);
    chk({tag, "_btaken"}, BranchTakenE, 0);
    chk({tag, "_memwr"}, MemWriteM, 0);
    chk({tag, "_regwr_w"}, RegWriteW, 0);
    chk({tag, "_mtr_w"}, MemtoRegW, 0);
    chk({tag, "_pcsrc_w"}, PCSrcW, 0);
    chk({tag, "_stallf"}, StallF, 0);
    chk({tag, "_stalld"}, StallD, 0);
    chk({tag, "_flushd"}, FlushD, 0);
    chk({tag, "_flushe"}, FlushE, 0);
  endtask

  // Scoreboard consumer: compare W-stage controls when the instruction is due
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      chk("sb_regwrite_w", RegWriteW, e.rw);
      chk("sb_memtoreg_w", MemtoRegW, e.mtr);
      chk("sb_pcsrc_w", PCSrcW, e.pcs);
    end
  end

  // Condition pass masks (bit k = code k passes) for each flag setting
  logic [15:0] pass_tab [4] = '{16'hD6AA, 16'hE655, 16'hEA9A, 16'hD5A6};
  logic [3:0]  flag_tab [4] = '{4'b0000, 4'b1111, 4'b1000, 4'b0010};

  initial begin
    d_t d, u;
    reset = 1'b1;
    ALUFlags = 4'b0000;
    drive(nop());
    #2;
    chk_all_zero("reset");
    step(); step();
    reset = 1'b0;

    // Plain AL register write reaches W after three edges
    d = nop(); d.rw = 1'b1; d.wa3 = 4'd3; d.asrc = 1'b1; d.actl = 2'b10;
    drive(d);
    settle(); chk("lat0_regwrite_w", RegWriteW, 0);
    step(); drive(nop()); settle();
    chk("lat1_regwrite_w", RegWriteW, 0);
    chk("lat1_alusrc_e", ALUSrcE, 1);
    chk("lat1_aluctl_e", ALUControlE, 2);
    step(); settle(); chk("lat2_regwrite_w", RegWriteW, 0);
    chk("lat2_alusrc_e", ALUSrcE, 0);
    step(); settle(); chk("lat3_regwrite_w", RegWriteW, 1);
    step(); settle(); chk("lat4_regwrite_w", RegWriteW, 0);

    // Scoreboard streams: all 16 condition codes under four flag settings
    for (int s = 0; s < 4; s++) begin
      step();
      ALUFlags = flag_tab[s];
      d = nop(); d.fw = 2'b11;
      drive(d);
      push(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        step();
        d = nop();
        d.cond = 4'(c);
        d.rw = 1'b1;
        d.mtr = 1'($urandom_range(0, 1));
        d.pcs = c[0];
        d.wa3 = 4'((c % 15) + 1);
        drive(d);
        push(pass_tab[s][c], d.mtr, d.pcs & pass_tab[s][c]);
      end
    end
    step(); drive(nop());
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) step();
    chk("sb_drained", sb_q.size(), 0);
    idle(2);

    // MemWrite gated by NE/EQ with Z=1
    step(); d = nop(); d.fw = 2'b11; drive(d);
    step(); ALUFlags = 4'b0100; d = nop(); d.mw = 1'b1; d.cond = COND_NE; drive(d);
    step(); d.cond = COND_EQ; drive(d);
    step(); drive(nop()); settle(); chk("memwrite_ne_z1", MemWriteM, 0);
    step(); settle(); chk("memwrite_eq_z1", MemWriteM, 1);
    idle(3);

    // Branches: NE not taken with Z=1, then AL taken flushes the next instruction
    step(); d = nop(); d.br = 1'b1; d.cond = COND_NE; drive(d);
    step(); drive(nop()); settle();
    chk("br_ne_taken", BranchTakenE, 0);
    chk("br_ne_flushe", FlushE, 0);
    step(); d = nop(); d.br = 1'b1; d.cond = COND_AL; drive(d);
    step(); d = nop(); d.rw = 1'b1; d.wa3 = 4'd6; drive(d); settle();
    chk("br_al_taken", BranchTakenE, 1);
    chk("br_al_flushd", FlushD, 1);
    chk("br_al_flushe", FlushE, 1);
    step(); drive(nop()); settle(); chk("br_after_taken", BranchTakenE, 0);
    step(); settle();
    step(); settle(); chk("br_flushed_regwrite_w", RegWriteW, 0);
    idle(3);

    // Load followed by a dependent instruction
    step(); d = nop(); d.rw = 1'b1; d.mtr = 1'b1; d.wa3 = 4'd2; drive(d);
    step(); u = nop(); u.rw = 1'b1; u.wa3 = 4'd7; u.ra1 = 4'd2; drive(u); settle();
    chk("ldr_stallf", StallF, 1);
    chk("ldr_stalld", StallD, 1);
    chk("ldr_flushe", FlushE, 1);
    chk("ldr_flushd", FlushD, 0);
    step(); settle();
`ifdef PIPE_CONTROLLER_FORWARD_EN
    chk("ldr_stalld_cyc2", StallD, 0);
    chk("ldr_flushe_cyc2", FlushE, 0);
`else
    chk("ldr_stalld_cyc2", StallD, 1);
`endif
    step();
`ifdef PIPE_CONTROLLER_FORWARD_EN
    drive(nop());
    settle();
    chk("ldr_fwda_w", ForwardAE, 1);
`else
    settle();
    chk("ldr_fwda_w", ForwardAE, 0);
`endif
    chk("ldr_fwdb_w", ForwardBE, 0);
    chk("ldr_stalld_cyc3", StallD, 0);
    idle(5);

    // r5 written by both M and W while the consumer reads r5 on port B
    step(); d = nop(); d.rw = 1'b1; d.wa3 = 4'd5; drive(d);
    step(); drive(d);
    step(); u = nop(); u.ra1 = 4'd9; u.ra2 = 4'd5; drive(u); settle();
`ifdef PIPE_CONTROLLER_FORWARD_EN
    chk("mw_stalld_cyc2", StallD, 0);
    step(); drive(nop()); settle();
    chk("mw_fwdb", ForwardBE, 2);
    chk("mw_fwda", ForwardAE, 0);
`else
    chk("mw_stalld_cyc2", StallD, 1);
    step(); settle();
    chk("mw_stalld_cyc3", StallD, 1);
    chk("mw_fwdb", ForwardBE, 0);
    step(); settle();
    chk("mw_stalld_cyc4", StallD, 0);
`endif
    idle(5);

    // Partial flag write: FlagWrite=10 with ALUFlags=1111 over flags 0000 -> 1100
    step(); d = nop(); d.fw = 2'b11; drive(d);
    step(); ALUFlags = 4'b0000; d = nop(); d.fw = 2'b10; drive(d);
    step(); ALUFlags = 4'b1111; d = nop(); d.br = 1'b1; d.cond = COND_CS; drive(d);
    step(); ALUFlags = 4'b0000; d.cond = COND_MI; drive(d); settle();
    chk("fw10_cs", BranchTakenE, 0);
    step(); drive(nop()); settle(); chk("fw10_mi", BranchTakenE, 1);
    step(); d.cond = COND_EQ; drive(d);
    step(); drive(nop()); settle(); chk("fw10_eq", BranchTakenE, 1);
    step(); d.cond = COND_VS; drive(d);
    step(); drive(nop()); settle(); chk("fw10_vs", BranchTakenE, 0);
    idle(4);

    // Reset asserted with instructions in flight
    step(); d = nop(); d.mw = 1'b1; d.rw = 1'b1; d.wa3 = 4'd4; d.asrc = 1'b1; d.actl = 2'b11; drive(d);
    step(); d = nop(); d.pcs = 1'b1; d.rw = 1'b1; d.wa3 = 4'd15; d.asrc = 1'b1; drive(d);
    step(); drive(nop());
    #1;
    chk("pre_rst_memwrite_m", MemWriteM, 1);
    chk("pre_rst_alusrc_e", ALUSrcE, 1);
    chk("pre_rst_stallf", StallF, 1);
    #1; reset = 1'b1;
    #1; chk_all_zero("rst_mid");
    step(); chk_all_zero("rst_held");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("post_rst_regwrite_w", RegWriteW, 0);
      chk("post_rst_pcsrc_w", PCSrcW, 0);
      chk("post_rst_memwrite_m", MemWriteM, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
